// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction opcodes, DR selection
// and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS   = 2'd0,
    DR_IDCODE   = 2'd1,
    DR_USERCODE = 2'd2
  } dr_sel_e;

  localparam logic [9:0] OPC_IDCODE   = 10'h059;
  localparam logic [9:0] OPC_BYPASS   = 10'h3FF;
  localparam logic [9:0] OPC_USERCODE = 10'h05A;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Two-flop synchronizer for one JTAG pin plus rise/fall detection against a
// one-cycle-delayed copy of the synchronized value.
module jtag_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    dly_d  = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign dout = sync_q[1];
  assign rise = sync_q[1] & ~dly_q;
  assign fall = ~sync_q[1] & dly_q;

endmodule

// File: rtl/jtag_tap.sv
// Oversampled IEEE 1149.1 TAP controller with IDCODE/BYPASS data registers.
// Define JTAG_USERCODE_EN to add the 32-bit USERCODE data register.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h0150203F,
  parameter int unsigned IR_LEN = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TCK,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_OE,
  input  logic [31:0]       USERCODE,
  output logic [3:0]        STATE,
  output logic [IR_LEN-1:0] IR
);

  localparam logic [IR_LEN-1:0] IR_IDCODE   = IR_LEN'(OPC_IDCODE);
  localparam logic [IR_LEN-1:0] IR_USERCODE = IR_LEN'(OPC_USERCODE);

  logic tck_s, tck_rise, tck_fall;
  logic tms_s, tms_rise, tms_fall;
  logic tdi_s, tdi_rise, tdi_fall;

  jtag_sync u_sync_tck (.clk(CLK), .rst(RST), .din(TCK), .dout(tck_s), .rise(tck_rise), .fall(tck_fall));
  jtag_sync u_sync_tms (.clk(CLK), .rst(RST), .din(TMS), .dout(tms_s), .rise(tms_rise), .fall(tms_fall));
  jtag_sync u_sync_tdi (.clk(CLK), .rst(RST), .din(TDI), .dout(tdi_s), .rise(tdi_rise), .fall(tdi_fall));

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d;
  logic [IR_LEN-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]       dr_sr_q, dr_sr_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;
  dr_sel_e           dr_sel;

`ifdef JTAG_USERCODE_EN
  logic unused_sync;
  assign unused_sync = ^{tck_s, tms_rise, tms_fall, tdi_rise, tdi_fall};
`else
  logic unused_sync;
  assign unused_sync = ^{tck_s, tms_rise, tms_fall, tdi_rise, tdi_fall, USERCODE};
`endif

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == IR_IDCODE) dr_sel = DR_IDCODE;
`ifdef JTAG_USERCODE_EN
    if (ir_q == IR_USERCODE) dr_sel = DR_USERCODE;
`endif
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    dr_sr_d  = dr_sr_q;
    tdo_d    = tdo_q;
    tdo_oe_d = tdo_oe_q;

    // Register actions belong to the state being left on this TCK rise.
    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
      case (state_q)
        CAPTURE_IR: ir_sr_d = IR_LEN'(1);
        SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_LEN-1:1]};
        CAPTURE_DR: begin
          dr_sr_d = '0;
          if (dr_sel == DR_IDCODE) dr_sr_d = IDCODE;
`ifdef JTAG_USERCODE_EN
          if (dr_sel == DR_USERCODE) dr_sr_d = USERCODE;
`endif
        end
        SHIFT_DR: begin
          if (dr_sel == DR_BYPASS) dr_sr_d = {31'b0, tdi_s};
          else                     dr_sr_d = {tdi_s, dr_sr_q[31:1]};
        end
        default: ;
      endcase
      if (state_d == UPDATE_IR && state_q != UPDATE_IR) ir_d = ir_sr_q;
      if (state_d == TEST_LOGIC_RESET) ir_d = IR_IDCODE;
    end

    if (tck_fall) begin
      tdo_oe_d = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
      tdo_d    = 1'b0;
      if (state_q == SHIFT_IR) tdo_d = ir_sr_q[0];
      if (state_q == SHIFT_DR) tdo_d = dr_sr_q[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= TEST_LOGIC_RESET;
      ir_q     <= IR_IDCODE;
      ir_sr_q  <= '0;
      dr_sr_q  <= '0;
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      dr_sr_q  <= dr_sr_d;
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign STATE  = state_q;
  assign IR     = ir_q;
  assign TDO    = tdo_q;
  assign TDO_OE = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Scoreboard bench for jtag_tap: each TCK pulse queues its expected post-fall
// STATE/IR/TDO_OE/TDO; a monitor checks them after every TCK fall.
module tb_jtag_tap;
  import jtag_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck = 1'b0;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        tdo_oe;
  logic [31:0] usercode;
  logic [3:0]  state;
  logic [9:0]  ir;

  always #5 clk = ~clk;

  jtag_tap #(.IDCODE(32'h0150203F), .IR_LEN(10)) dut (
    .CLK(clk), .RST(rst), .TCK(tck), .TMS(tms), .TDI(tdi),
    .TDO(tdo), .TDO_OE(tdo_oe), .USERCODE(usercode), .STATE(state), .IR(ir)
  );

  typedef struct {
    logic       chk;
    string      name;
    logic [3:0] st;
    logic [9:0] irv;
    logic       oe;
    logic       o;
  } exp_t;

  exp_t q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: TDO/TDO_OE settle a few CLKs after the DUT sees the TCK fall.
  always @(negedge tck) begin
    exp_t e;
    repeat (6) @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue expected an entry");
    end else begin
      e = q.pop_front();
      if (e.chk) begin
        check({e.name, "_state"}, 32'(state), 32'(e.st));
        check({e.name, "_ir"}, 32'(ir), 32'(e.irv));
        check({e.name, "_oe_tdo"}, 32'({tdo_oe, tdo}), 32'({e.oe, e.o}));
      end
    end
  end

  task automatic pulse(input logic m, input logic d, input logic chk, input string name,
                       input tap_state_e st, input logic [9:0] irv, input logic oe, input logic o);
    exp_t e;
    e.chk = chk; e.name = name; e.st = st; e.irv = irv; e.oe = oe; e.o = o;
    q.push_back(e);
    tms = m;
    tdi = d;
    repeat (8) @(posedge clk);
    #1 tck = 1'b1;
    repeat (8) @(posedge clk);
    #1 tck = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic pulse_nc(input logic m);
    pulse(m, 1'b0, 1'b0, "", TEST_LOGIC_RESET, 10'h000, 1'b0, 1'b0);
  endtask

  task automatic goto_shift_dr(input string name, input logic [9:0] irv, input logic first);
    pulse(1'b1, 1'b0, 1'b1, {name, "_seldr"}, SELECT_DR_SCAN, irv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_capdr"}, CAPTURE_DR, irv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_bit0"}, SHIFT_DR, irv, 1'b1, first);
  endtask

  task automatic exit_dr(input string name, input logic [9:0] irv);
    pulse(1'b1, 1'b0, 1'b1, {name, "_exit1"}, EXIT1_DR, irv, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, {name, "_upd"}, UPDATE_DR, irv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_rti"}, RUN_TEST_IDLE, irv, 1'b0, 1'b0);
  endtask

  task automatic read_dr32(input string name, input logic [31:0] word, input logic [9:0] irv);
    logic [31:0] w;
    w = word;
    goto_shift_dr(name, irv, w[0]);
    for (int i = 1; i < 32; i++)
      pulse(1'b0, 1'b0, 1'b1, $sformatf("%s_bit%0d", name, i), SHIFT_DR, irv, 1'b1, w[i]);
    exit_dr(name, irv);
  endtask

  // Captured IR pattern is ...0001, so TDO reads 1 then zeros during the shift.
  task automatic load_ir(input string name, input logic [9:0] newv, input logic [9:0] oldv);
    logic [9:0] v;
    v = newv;
    pulse(1'b1, 1'b0, 1'b1, {name, "_seldr"}, SELECT_DR_SCAN, oldv, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, {name, "_selir"}, SELECT_IR_SCAN, oldv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_capir"}, CAPTURE_IR, oldv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_irbit0"}, SHIFT_IR, oldv, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++)
      pulse(1'b0, v[i], 1'b1, $sformatf("%s_irbit%0d", name, i + 1), SHIFT_IR, oldv, 1'b1, 1'b0);
    pulse(1'b1, v[9], 1'b1, {name, "_exit1"}, EXIT1_IR, oldv, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, {name, "_upd"}, UPDATE_IR, newv, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, {name, "_rti"}, RUN_TEST_IDLE, newv, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    usercode = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'(TEST_LOGIC_RESET));
    check("rst_ir", 32'(ir), 32'h059);
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_oe", 32'(tdo_oe), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) pulse_nc(1'b1);
    pulse(1'b1, 1'b0, 1'b1, "tlr5", TEST_LOGIC_RESET, 10'h059, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, "rti", RUN_TEST_IDLE, 10'h059, 1'b0, 1'b0);

    read_dr32("idcode", 32'h0150203F, 10'h059);

    load_ir("ir_bypass", 10'h3FF, 10'h059);
    goto_shift_dr("byp", 10'h3FF, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, "byp_s1", SHIFT_DR, 10'h3FF, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, "byp_s2", SHIFT_DR, 10'h3FF, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, "byp_s3", SHIFT_DR, 10'h3FF, 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b1, "byp_s4", SHIFT_DR, 10'h3FF, 1'b1, 1'b1);
    exit_dr("byp", 10'h3FF);

    load_ir("ir_user", 10'h05A, 10'h3FF);
`ifdef JTAG_USERCODE_EN
    read_dr32("usercode", 32'hCAFEF00D, 10'h05A);
`else
    goto_shift_dr("user_byp", 10'h05A, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, "user_byp_s1", SHIFT_DR, 10'h05A, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, "user_byp_s2", SHIFT_DR, 10'h05A, 1'b1, 1'b0);
    exit_dr("user_byp", 10'h05A);
`endif

    pulse(1'b1, 1'b0, 1'b1, "tms_seldr", SELECT_DR_SCAN, 10'h05A, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "tms_selir", SELECT_IR_SCAN, 10'h05A, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "tms_tlr", TEST_LOGIC_RESET, 10'h059, 1'b0, 1'b0);
    pulse_nc(1'b1);
    pulse_nc(1'b1);

    pulse(1'b0, 1'b0, 1'b1, "mid_rti", RUN_TEST_IDLE, 10'h059, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "mid_seldr", SELECT_DR_SCAN, 10'h059, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "mid_selir", SELECT_IR_SCAN, 10'h059, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, "mid_capir", CAPTURE_IR, 10'h059, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, "mid_shift0", SHIFT_IR, 10'h059, 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b1, "mid_shift1", SHIFT_IR, 10'h059, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_state", 32'(state), 32'(TEST_LOGIC_RESET));
    check("midrst_ir", 32'(ir), 32'h059);
    check("midrst_oe_tdo", 32'({tdo_oe, tdo}), 32'h0);
    pulse(1'b0, 1'b0, 1'b1, "post_rti", RUN_TEST_IDLE, 10'h059, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "post_seldr", SELECT_DR_SCAN, 10'h059, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, "post_selir", SELECT_IR_SCAN, 10'h059, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, "post_capir", CAPTURE_IR, 10'h059, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, "post_shift0", SHIFT_IR, 10'h059, 1'b1, 1'b1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
